// File: rtl/jpeg_mcu_serializer.sv
// rtl/jpeg_mcu_serializer.sv - gathers per-channel coefficient blocks into one MCU-ordered stream
`timescale 1ns/1ps
module jpeg_mcu_serializer #(
    parameter int DATA_WIDTH = 10,
    parameter int CHANNELS   = 3,
    parameter int BLOCK_SIZE = 64,
    parameter int MCU_CNT_W  = 16,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IDX_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           chroma_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CH_W-1:0]                out_chan,
    output logic                           out_first,
    output logic                           out_last,
    output logic                           mcu_done,
    output logic [MCU_CNT_W-1:0]           mcu_count
);

    localparam int               ADDR_W   = CH_W + 1 + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DROP} state_t;

    // Buffer address is {channel, bank, coefficient index}.
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];

    logic [1:0]            full_q   [CHANNELS];
    logic [IDX_W-1:0]      wr_idx_q [CHANNELS];
    logic [CHANNELS-1:0]   wr_bank_q;
    logic [CHANNELS-1:0]   rd_bank_q;

    state_t                state_q;
    logic [CH_W-1:0]       ch_q;
    logic [CH_W-1:0]       ch_d;
    logic                  mode_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [IDX_W-1:0]      rd_idx_d;
    logic                  release_bank;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_chan_q;
    logic                  out_first_q;
    logic                  out_last_q;
    logic                  mcu_done_q;
    logic [MCU_CNT_W-1:0]  mcu_count_q;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !full_q[i][wr_bank_q[i]];
        end
        release_bank = (state_q == DROP) ||
                       ((state_q == SEND) && out_valid_q && out_ready && out_last_q);
        ch_d         = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        rd_idx_d     = rd_idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    mem_q[{CH_W'(i), wr_bank_q[i], wr_idx_q[i]}] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Fill and release of one channel in the same cycle always touch opposite banks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                full_q[i]   <= '0;
                wr_idx_q[i] <= '0;
            end
            wr_bank_q <= '0;
            rd_bank_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    if (wr_idx_q[i] == LAST_IDX) begin
                        wr_idx_q[i]             <= '0;
                        full_q[i][wr_bank_q[i]] <= 1'b1;
                        wr_bank_q[i]            <= ~wr_bank_q[i];
                    end else begin
                        wr_idx_q[i] <= wr_idx_q[i] + 1'b1;
                    end
                end
            end
            if (release_bank) begin
                full_q[ch_q][rd_bank_q[ch_q]] <= 1'b0;
                rd_bank_q[ch_q]               <= ~rd_bank_q[ch_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            mode_q      <= 1'b0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            mcu_done_q  <= 1'b0;
            mcu_count_q <= '0;
        end else begin
            mcu_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (full_q[ch_q][rd_bank_q[ch_q]]) begin
                        if (ch_q == '0) begin
                            mode_q  <= chroma_en;
                            state_q <= FETCH;
                        end else if (!mode_q) begin
                            state_q <= DROP;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= mem_q[{ch_q, rd_bank_q[ch_q], {IDX_W{1'b0}}}];
                    out_chan_q  <= ch_q;
                    out_first_q <= 1'b1;
                    out_last_q  <= (BLOCK_SIZE == 1);
                    rd_idx_q    <= '0;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_first_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            ch_q        <= ch_d;
                            if (ch_q == LAST_CH) begin
                                mcu_done_q  <= 1'b1;
                                mcu_count_q <= mcu_count_q + 1'b1;
                            end
                            state_q <= IDLE;
                        end else begin
                            // Prefetch the next word straight into the output register.
                            rd_idx_q    <= rd_idx_d;
                            out_data_q  <= mem_q[{ch_q, rd_bank_q[ch_q], rd_idx_d}];
                            out_first_q <= 1'b0;
                            out_last_q  <= (rd_idx_d == LAST_IDX);
                        end
                    end
                end
                DROP: begin
                    ch_q <= ch_d;
                    if (ch_q == LAST_CH) begin
                        mcu_done_q  <= 1'b1;
                        mcu_count_q <= mcu_count_q + 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign mcu_done  = mcu_done_q;
    assign mcu_count = mcu_count_q;

endmodule

// File: tb/tb_jpeg_mcu_serializer.sv
// tb/tb_jpeg_mcu_serializer.sv - randomized self-checking bench for jpeg_mcu_serializer
`timescale 1ns/1ps
module tb_jpeg_mcu_serializer;
    localparam int DW  = 10;
    localparam int NCH = 3;
    localparam int BS  = 64;

    typedef struct packed {
        logic [1:0]    chan;
        logic          first;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*DW-1:0] in_data;
    logic              chroma_en;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_chan;
    logic              out_first;
    logic              out_last;
    logic              mcu_done;
    logic [15:0]       mcu_count;

    always #5 clk = ~clk;

    jpeg_mcu_serializer #(
        .DATA_WIDTH(DW), .CHANNELS(NCH), .BLOCK_SIZE(BS), .MCU_CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .chroma_en(chroma_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_first(out_first), .out_last(out_last),
        .mcu_done(mcu_done), .mcu_count(mcu_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] src0[$], src1[$], src2[$];
    logic [DW-1:0] sent0[$], sent1[$], sent2[$];
    beat_t obs[$], exp_q[$];
    int obs_cyc[$];
    int cyc = 0, n_done = 0, hold_err = 0, rdy_mode = 0, pat_i = 0;

    // Source driver: one pending word per channel, popped once the DUT has taken it.
    initial begin : driver
        logic [NCH-1:0] fire;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready & {NCH{rst_n}};
            @(posedge clk);
            #1;
            cyc++;
            if (fire[0] && src0.size() > 0) void'(src0.pop_front());
            if (fire[1] && src1.size() > 0) void'(src1.pop_front());
            if (fire[2] && src2.size() > 0) void'(src2.pop_front());
            in_valid = {src2.size() > 0, src1.size() > 0, src0.size() > 0};
            in_data[0*DW +: DW] = (src0.size() > 0) ? src0[0] : '0;
            in_data[1*DW +: DW] = (src1.size() > 0) ? src1[0] : '0;
            in_data[2*DW +: DW] = (src2.size() > 0) ? src2[0] : '0;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                    pat_i++;
                end
            endcase
        end
    end

    initial begin : monitor
        beat_t cur, prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = {out_chan, out_first, out_last, out_data};
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!out_valid || cur != prev)) hold_err++;
                if (out_valid && out_ready) begin
                    obs.push_back(cur);
                    obs_cyc.push_back(cyc);
                end
                if (mcu_done) n_done++;
                prev_stall = out_valid && !out_ready;
                prev       = cur;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        src0.delete(); src1.delete(); src2.delete();
        sent0.delete(); sent1.delete(); sent2.delete();
        repeat (2) @(posedge clk);
        #1;
        obs.delete(); obs_cyc.delete(); exp_q.delete();
        n_done = 0; hold_err = 0;
        rst_n = 1'b1;
    endtask

    task automatic push_block(input int c, input bit rnd);
        logic [DW-1:0] v;
        for (int k = 0; k < BS; k++) begin
            v = rnd ? DW'($urandom_range(0, 1023)) : DW'(c * 256 + k);
            case (c)
                0: begin src0.push_back(v); sent0.push_back(v); end
                1: begin src1.push_back(v); sent1.push_back(v); end
                default: begin src2.push_back(v); sent2.push_back(v); end
            endcase
        end
    endtask

    // Reference: MCU m takes the m-th block of every channel; chroma blocks appear only if modes[m].
    task automatic build_expected(input int nmcu, input bit [7:0] modes);
        beat_t b;
        exp_q.delete();
        for (int m = 0; m < nmcu; m++) begin
            for (int c = 0; c < NCH; c++) begin
                if (c == 0 || modes[m]) begin
                    for (int k = 0; k < BS; k++) begin
                        b.chan  = 2'(c);
                        b.first = (k == 0);
                        b.last  = (k == BS - 1);
                        b.data  = (c == 0) ? sent0[m*BS+k] : (c == 1) ? sent1[m*BS+k] : sent2[m*BS+k];
                        exp_q.push_back(b);
                    end
                end
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs[i] !== exp_q[i]) return i;
        if (obs.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic beat_t obs_at(input int i);
        beat_t r;
        r = 'x;
        if (i >= 0 && i < obs.size()) r = obs[i];
        return r;
    endfunction

    function automatic beat_t exp_at(input int i);
        beat_t r;
        r = 'x;
        if (i >= 0 && i < exp_q.size()) r = exp_q[i];
        return r;
    endfunction

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (obs.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (40) @(posedge clk);
    endtask

    task automatic test_reset();
        chroma_en = 1'b1;
        rdy_mode  = 0;
        do_reset();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_tests++;
        if (in_ready !== 3'b111) begin n_fail++; $display("FAIL rst_in_ready: got %b want 111", in_ready); end
        n_tests++;
        if (mcu_count !== 16'd0) begin n_fail++; $display("FAIL rst_mcu_count: got %0d want 0", mcu_count); end
        n_tests++;
        if ({out_data, out_chan, out_first, out_last, mcu_done} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_outputs: got %h want 0", {out_data, out_chan, out_first, out_last, mcu_done});
        end
    endtask

    task automatic test_full_mcu();
        int d, gaps;
        rdy_mode  = 0;
        chroma_en = 1'b1;
        do_reset();
        for (int c = 0; c < NCH; c++) push_block(c, 1'b0);
        build_expected(1, 8'h01);
        wait_beats(192, 3000);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL t1_seq: beat %0d got %h (of %0d) want %h (of %0d)", d, obs_at(d), obs.size(), exp_at(d), exp_q.size());
        end
        n_tests++;
        if (obs.size() !== 192) begin n_fail++; $display("FAIL t1_count: got %0d want 192", obs.size()); end
        n_tests++;
        if (n_done !== 1) begin n_fail++; $display("FAIL t1_mcu_done: got %0d pulses want 1", n_done); end
        n_tests++;
        if (mcu_count !== 16'd1) begin n_fail++; $display("FAIL t1_mcu_count: got %0d want 1", mcu_count); end
        gaps = 0;
        for (int i = 1; i < obs.size(); i++) begin
            if (!obs[i].first && obs_cyc[i] != obs_cyc[i-1] + 1) gaps++;
        end
        n_tests++;
        if (gaps !== 0) begin n_fail++; $display("FAIL t1_no_bubbles: got %0d gaps want 0", gaps); end
    endtask

    task automatic test_grayscale();
        int d;
        rdy_mode  = 0;
        chroma_en = 1'b0;
        do_reset();
        for (int c = 0; c < NCH; c++) push_block(c, 1'b0);
        build_expected(1, 8'h00);
        wait_beats(64, 3000);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL t2_seq: beat %0d got %h (of %0d) want %h (of %0d)", d, obs_at(d), obs.size(), exp_at(d), exp_q.size());
        end
        n_tests++;
        if (n_done !== 1) begin n_fail++; $display("FAIL t2_mcu_done: got %0d pulses want 1", n_done); end
        n_tests++;
        if (mcu_count !== 16'd1) begin n_fail++; $display("FAIL t2_mcu_count: got %0d want 1", mcu_count); end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 3'b111) begin n_fail++; $display("FAIL t2_in_ready: got %b want 111", in_ready); end
    endtask

    task automatic test_ch2_backlog();
        int d;
        rdy_mode  = 1;
        chroma_en = 1'b1;
        do_reset();
        for (int b = 0; b < 3; b++) push_block(2, 1'b1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready[2] !== 1'b0) begin n_fail++; $display("FAIL t3_ready2: got %b want 0", in_ready[2]); end
        n_tests++;
        if (out_valid !== 1'b0 || obs.size() !== 0) begin
            n_fail++;
            $display("FAIL t3_no_output: got valid %b beats %0d want 0 0", out_valid, obs.size());
        end
        n_tests++;
        if (src2.size() !== BS) begin n_fail++; $display("FAIL t3_backlog: got %0d pending want %0d", src2.size(), BS); end
        for (int b = 0; b < 3; b++) begin
            push_block(0, 1'b1);
            push_block(1, 1'b1);
        end
        build_expected(3, 8'h07);
        wait_beats(576, 8000);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL t3_seq: beat %0d got %h (of %0d) want %h (of %0d)", d, obs_at(d), obs.size(), exp_at(d), exp_q.size());
        end
        n_tests++;
        if (mcu_count !== 16'd3) begin n_fail++; $display("FAIL t3_mcu_count: got %0d want 3", mcu_count); end
    endtask

    task automatic test_stall();
        int d;
        rdy_mode  = 2;
        pat_i     = 0;
        chroma_en = 1'b1;
        do_reset();
        for (int b = 0; b < 2; b++) for (int c = 0; c < NCH; c++) push_block(c, 1'b1);
        build_expected(2, 8'h03);
        wait_beats(384, 8000);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL t4_seq: beat %0d got %h (of %0d) want %h (of %0d)", d, obs_at(d), obs.size(), exp_at(d), exp_q.size());
        end
        n_tests++;
        if (hold_err !== 0) begin n_fail++; $display("FAIL t4_hold: got %0d unstable stalls want 0", hold_err); end
        n_tests++;
        if (mcu_count !== 16'd2) begin n_fail++; $display("FAIL t4_mcu_count: got %0d want 2", mcu_count); end
    endtask

    task automatic test_reset_mid();
        int d, t;
        rdy_mode  = 0;
        chroma_en = 1'b1;
        do_reset();
        for (int b = 0; b < 2; b++) for (int c = 0; c < NCH; c++) push_block(c, 1'b1);
        t = 0;
        while (obs.size() < 286 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        n_tests++;
        if (obs.size() < 286) begin n_fail++; $display("FAIL t5_reach: got %0d beats want 286", obs.size()); end
        #1;
        rst_n = 1'b0;
        src0.delete(); src1.delete(); src2.delete();
        @(posedge clk);
        #1;
        sent0.delete(); sent1.delete(); sent2.delete();
        obs.delete(); obs_cyc.delete();
        n_done = 0;
        rst_n  = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t5_valid: got %b want 0", out_valid); end
        n_tests++;
        if (mcu_count !== 16'd0) begin n_fail++; $display("FAIL t5_mcu_count_rst: got %0d want 0", mcu_count); end
        n_tests++;
        if (in_ready !== 3'b111) begin n_fail++; $display("FAIL t5_in_ready: got %b want 111", in_ready); end
        for (int c = 0; c < NCH; c++) push_block(c, 1'b1);
        build_expected(1, 8'h01);
        wait_beats(192, 3000);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL t5_seq: beat %0d got %h (of %0d) want %h (of %0d)", d, obs_at(d), obs.size(), exp_at(d), exp_q.size());
        end
        n_tests++;
        if (mcu_count !== 16'd1) begin n_fail++; $display("FAIL t5_mcu_count: got %0d want 1", mcu_count); end
    endtask

    task automatic test_mode_switch();
        int d, t;
        rdy_mode  = 1;
        chroma_en = 1'b1;
        do_reset();
        for (int b = 0; b < 2; b++) for (int c = 0; c < NCH; c++) push_block(c, 1'b1);
        t = 0;
        while (obs.size() < 65 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chroma_en = 1'b0;
        build_expected(2, 8'h01);
        wait_beats(256, 8000);
        d = first_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL t6_seq: beat %0d got %h (of %0d) want %h (of %0d)", d, obs_at(d), obs.size(), exp_at(d), exp_q.size());
        end
        n_tests++;
        if (mcu_count !== 16'd2) begin n_fail++; $display("FAIL t6_mcu_count: got %0d want 2", mcu_count); end
        n_tests++;
        if (n_done !== 2) begin n_fail++; $display("FAIL t6_mcu_done: got %0d pulses want 2", n_done); end
    endtask

    initial begin
        rst_n     = 1'b0;
        chroma_en = 1'b1;
        test_reset();
        test_full_mcu();
        test_grayscale();
        test_ch2_backlog();
        test_stall();
        test_reset_mid();
        test_mode_switch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
